// File: rtl/ccg_bist_pkg.sv
// Shared types and default constants for the CCG response compactor.
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_IN_W  = 10;
  localparam int unsigned DEF_SIG_W = 16;
  localparam int unsigned DEF_CNT_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'hFFFF;

endpackage

// File: rtl/ccg_resp_misr_if.sv
// Response-word handshake between the circuit-under-test and the compactor.
interface ccg_resp_misr_if
  import ccg_bist_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] f;

  modport master (output in_valid, output f, input in_ready);
  modport slave  (input in_valid, input f, output in_ready);
endinterface

// File: rtl/ccg_misr16.sv
// Multiple-input signature register: shift with polynomial feedback, XOR in data.
module ccg_misr16
  import ccg_bist_pkg::*;
#(
  parameter int unsigned      IN_W    = DEF_IN_W,
  parameter int unsigned      SIG_W   = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] RST_VAL = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] seed,
  input  logic [IN_W-1:0]  data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_nxt;

  // Next signature: shift left, fold in feedback taps, XOR in the zero-extended word.
  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0}
            ^ (sig[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-IN_W){1'b0}}, data};
  end

  // Signature register; load takes priority over a compaction step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/ccg_resp_misr.sv
// Response compactor: run control, pattern counter, expected-value latch and compare.
module ccg_resp_misr
  import ccg_bist_pkg::*;
#(
  parameter int unsigned      IN_W  = DEF_IN_W,
  parameter int unsigned      SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
  parameter int unsigned      CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_patterns,
  input  logic [SIG_W-1:0]   exp_sig,
  ccg_resp_misr_if.slave     resp,
  output logic               busy,
  output logic [CNT_W-1:0]   pat_count,
  output logic               sig_valid,
  output logic [SIG_W-1:0]   signature,
  output logic               pass,
  input  logic               sig_ack
);

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [SIG_W-1:0] exp_lat;
  logic             in_ready_q;
  logic             sig_valid_q;
  logic             launch;
  logic             accept;
  logic [CNT_W-1:0] cnt_nxt;

  // Start is honoured in IDLE and DONE (where it doubles as the acknowledge), never in RUN.
  always_comb begin
    launch  = start & (state != ST_RUN);
    accept  = resp.in_valid & in_ready_q;
    cnt_nxt = pat_count + CNT_W'(1);
  end

  ccg_misr16 #(
    .IN_W    (IN_W),
    .SIG_W   (SIG_W),
    .POLY    (POLY),
    .RST_VAL (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .en   (accept),
    .seed (SEED),
    .data (resp.f),
    .sig  (signature)
  );

  // Run control FSM with registered handshake/result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pat_count   <= '0;
      num_lat     <= '0;
      exp_lat     <= '0;
      in_ready_q  <= 1'b0;
      sig_valid_q <= 1'b0;
    end else if (launch) begin
      num_lat   <= num_patterns;
      exp_lat   <= exp_sig;
      pat_count <= '0;
      if (num_patterns == '0) begin
        state       <= ST_DONE;
        in_ready_q  <= 1'b0;
        sig_valid_q <= 1'b1;
      end else begin
        state       <= ST_RUN;
        in_ready_q  <= 1'b1;
        sig_valid_q <= 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            pat_count <= cnt_nxt;
            if (cnt_nxt == num_lat) begin
              state       <= ST_DONE;
              in_ready_q  <= 1'b0;
              sig_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (sig_ack) begin
            state       <= ST_IDLE;
            sig_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp.in_ready = in_ready_q;
  assign sig_valid     = sig_valid_q;
  assign busy          = (state == ST_RUN);
  assign pass          = (signature == exp_lat);

endmodule

// File: tb/tb_ccg_resp_misr.sv
// Randomised self-checking bench for ccg_resp_misr against an arithmetic MISR model.
module tb_ccg_resp_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        sig_ack = 1'b0;
  logic [15:0] num_patterns = '0;
  logic [15:0] exp_sig = '0;

  logic        busy, sig_valid, pass;
  logic [15:0] pat_count, signature;
  logic        busy0, sig_valid0, pass0;
  logic [15:0] pat_count0, signature0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [9:0]  fw [100];
  logic [15:0] m_sig;
  int unsigned m_cnt;

  ccg_resp_misr_if #(.IN_W(10)) resp ();
  ccg_resp_misr_if #(.IN_W(10)) resp0 ();

  ccg_resp_misr dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_patterns (num_patterns),
    .exp_sig      (exp_sig),
    .resp         (resp.slave),
    .busy         (busy),
    .pat_count    (pat_count),
    .sig_valid    (sig_valid),
    .signature    (signature),
    .pass         (pass),
    .sig_ack      (sig_ack)
  );

  ccg_resp_misr #(.SEED(16'h0000)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .start        (start0),
    .num_patterns (num_patterns),
    .exp_sig      (exp_sig),
    .resp         (resp0.slave),
    .busy         (busy0),
    .pat_count    (pat_count0),
    .sig_valid    (sig_valid0),
    .signature    (signature0),
    .pass         (pass0),
    .sig_ack      (sig_ack)
  );

  always #5 clk = ~clk;

  // Reference step: multiply by x modulo the polynomial, then add the word.
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [9:0] w);
    int unsigned x;
    x = 32'(s) * 2;
    if (x >= 65536) x = (x - 65536) ^ 32'h1021;
    x = x ^ 32'(w);
    return x[15:0];
  endfunction

  function automatic logic [15:0] ref_sig(input logic [15:0] seed, input int unsigned n);
    logic [15:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = ref_step(s, fw[i]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words();
    for (int i = 0; i < 100; i++) fw[i] = 10'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resp.in_valid  = 1'b0;
    resp.f         = '0;
    resp0.in_valid = 1'b0;
    resp0.f        = '0;
    #12;
    check("rst_sig",       32'(signature),  32'hFFFF);
    check("rst_cnt",       32'(pat_count),  32'h0);
    check("rst_ready",     32'(resp.in_ready), 32'h0);
    check("rst_busy",      32'(busy),       32'h0);
    check("rst_valid",     32'(sig_valid),  32'h0);
    check("rst_sig_seed0", 32'(signature0), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // One beat of zero from the default seed.
    num_patterns = 16'd1; exp_sig = 16'hEFDF; start = 1'b1;
    check("t1_ready_in_start", 32'(resp.in_ready), 32'h0);
    tick();
    start = 1'b0;
    check("t1_ready", 32'(resp.in_ready), 32'h1);
    check("t1_busy",  32'(busy), 32'h1);
    resp.in_valid = 1'b1; resp.f = 10'h000;
    tick();
    resp.in_valid = 1'b0;
    check("t1_sig",   32'(signature), 32'hEFDF);
    check("t1_valid", 32'(sig_valid), 32'h1);
    check("t1_ready_done", 32'(resp.in_ready), 32'h0);
    check("t1_pass",  32'(pass), 32'h1);
    check("t1_cnt",   32'(pat_count), 32'h1);
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;
    check("t1_ack", 32'(sig_valid), 32'h0);

    // Zero seed, two all-ones beats.
    num_patterns = 16'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    resp0.in_valid = 1'b1; resp0.f = 10'h3FF;
    tick();
    check("t2_sig_b1", 32'(signature0), 32'h03FF);
    tick();
    resp0.in_valid = 1'b0;
    check("t2_sig_b2", 32'(signature0), 32'h0401);
    check("t2_cnt",    32'(pat_count0), 32'h2);
    check("t2_valid",  32'(sig_valid0), 32'h1);
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;

    // Empty run.
    num_patterns = 16'd0; exp_sig = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_valid", 32'(sig_valid), 32'h1);
    check("t3_sig",   32'(signature), 32'hFFFF);
    check("t3_ready", 32'(resp.in_ready), 32'h0);
    check("t3_pass",  32'(pass), 32'h1);
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;

    // 100 beats with random valid; a start mid-run must be ignored.
    fill_words();
    num_patterns = 16'd100; exp_sig = ref_sig(16'hFFFF, 100); start = 1'b1;
    tick();
    start = 1'b0;
    m_sig = 16'hFFFF; m_cnt = 0;
    for (int cyc = 0; cyc < 2000 && m_cnt < 100; cyc++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      resp.in_valid = v;
      resp.f = fw[m_cnt];
      if (cyc == 40) begin
        start = 1'b1; num_patterns = 16'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      if (v) begin
        m_sig = ref_step(m_sig, fw[m_cnt]);
        m_cnt++;
      end
      check("t4_sig",   32'(signature), 32'(m_sig));
      check("t4_cnt",   32'(pat_count), 32'(m_cnt));
      check("t4_ready", 32'(resp.in_ready), (m_cnt < 100) ? 32'h1 : 32'h0);
    end
    start = 1'b0;
    check("t4_beats", m_cnt, 100);
    resp.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_ready", 32'(resp.in_ready), 32'h0);
      check("t4_hold_sig",   32'(signature), 32'(m_sig));
      check("t4_hold_cnt",   32'(pat_count), 32'd100);
    end
    resp.in_valid = 1'b0;
    check("t4_valid", 32'(sig_valid), 32'h1);
    check("t4_pass",  32'(pass), 32'h1);

    // Start in DONE with ack also high: restart with seed reloaded.
    fill_words();
    num_patterns = 16'd3; exp_sig = ref_sig(16'hFFFF, 3);
    start = 1'b1; sig_ack = 1'b1;
    tick();
    start = 1'b0; sig_ack = 1'b0;
    check("t5_busy",  32'(busy), 32'h1);
    check("t5_seed",  32'(signature), 32'hFFFF);
    check("t5_cnt",   32'(pat_count), 32'h0);
    check("t5_valid", 32'(sig_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      resp.in_valid = 1'b1; resp.f = fw[i];
      tick();
    end
    resp.in_valid = 1'b0;
    check("t5_sig",   32'(signature), 32'(exp_sig));
    check("t5_pass",  32'(pass), 32'h1);
    check("t5_done",  32'(sig_valid), 32'h1);
    sig_ack = 1'b1;
    tick();
    sig_ack = 1'b0;

    // Reset in the middle of a 10-beat run, then a clean rerun.
    fill_words();
    num_patterns = 16'd10; exp_sig = ref_sig(16'hFFFF, 10); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      resp.in_valid = 1'b1; resp.f = fw[i];
      tick();
    end
    check("t6_mid_sig", 32'(signature), 32'(ref_sig(16'hFFFF, 5)));
    rst = 1'b1;
    #1;
    check("t6_rst_sig",   32'(signature), 32'hFFFF);
    check("t6_rst_cnt",   32'(pat_count), 32'h0);
    check("t6_rst_ready", 32'(resp.in_ready), 32'h0);
    check("t6_rst_busy",  32'(busy), 32'h0);
    check("t6_rst_valid", 32'(sig_valid), 32'h0);
    check("t6_rst_pass",  32'(pass), 32'h0);
    #1;
    rst = 1'b0;
    resp.in_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      resp.in_valid = 1'b1; resp.f = fw[i];
      tick();
    end
    resp.in_valid = 1'b0;
    check("t6_sig",   32'(signature), 32'(exp_sig));
    check("t6_cnt",   32'(pat_count), 32'd10);
    check("t6_valid", 32'(sig_valid), 32'h1);
    check("t6_pass",  32'(pass), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
